// File: rtl/pe_array_sequencer_if.sv
// Scheduler/array-side signal bundle for pe_array_sequencer.
// The scheduler (or bench) drives through master; the sequencer uses slave.
interface pe_array_sequencer_if #(
   parameter int N   = 4,
   parameter int K_W = 8
);
   logic           i_start;
   logic [K_W-1:0] i_k_len;
   logic           i_abort;
   logic           o_busy;
   logic           o_pe_clear;
   logic           o_rd_en;
   logic [K_W-1:0] o_rd_addr;
   logic [N-1:0]   o_feed_valid;
   logic           o_capture;
   logic           o_done;

   modport master (
      output i_start, i_k_len, i_abort,
      input  o_busy, o_pe_clear, o_rd_en, o_rd_addr, o_feed_valid, o_capture, o_done
   );

   modport slave (
      input  i_start, i_k_len, i_abort,
      output o_busy, o_pe_clear, o_rd_en, o_rd_addr, o_feed_valid, o_capture, o_done
   );
endinterface

// File: rtl/pe_array_sequencer.sv
// Sequences an N x N systolic MAC array through one tile: clear, K operand
// reads with skewed row strobes, pipeline drain, then a capture/done pulse.
module pe_array_sequencer #(
   parameter int N     = 4,
   parameter int K_W   = 8,
   parameter int P_LAT = 3
) (
   input  logic                i_clock,
   input  logic                i_reset,
   pe_array_sequencer_if.slave bus
);
   // Buffer read latency + worst-case row/column skew + PE latency.
   localparam int D  = 1 + 2 * (N - 1) + P_LAT;
   localparam int DW = $clog2(D + 1);

   typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

   state_t         state, state_nxt;
   logic [K_W-1:0] k_reg, k_nxt;
   logic [K_W-1:0] addr, addr_nxt;
   logic [DW-1:0]  dcnt, dcnt_nxt;
   logic [N-1:0]   vld_pipe;
   logic           rd_en;

   assign rd_en = (state == FEED);

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state    <= IDLE;
         k_reg    <= '0;
         addr     <= '0;
         dcnt     <= '0;
         vld_pipe <= '0;
      end else begin
         state <= state_nxt;
         k_reg <= k_nxt;
         addr  <= addr_nxt;
         dcnt  <= dcnt_nxt;
         // Stage 0 is rd_en one cycle late (buffer latency); each row adds one more.
         if (bus.i_abort) begin
            vld_pipe <= '0;
         end else begin
            vld_pipe[0] <= rd_en;
            for (int r = 1; r < N; r++) vld_pipe[r] <= vld_pipe[r-1];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      k_nxt     = k_reg;
      addr_nxt  = addr;
      dcnt_nxt  = dcnt;
      unique case (state)
         IDLE: begin
            if (bus.i_start) begin
               k_nxt     = bus.i_k_len;
               state_nxt = CLEAR;
            end
         end
         CLEAR: begin
            addr_nxt  = '0;
            state_nxt = (k_reg == '0) ? DONE : FEED;
         end
         FEED: begin
            // k_reg <= 2^K_W-1, so the increment never needs to wrap.
            if (addr == k_reg - K_W'(1)) begin
               state_nxt = DRAIN;
               dcnt_nxt  = DW'(D - 1);
            end else begin
               addr_nxt = addr + K_W'(1);
            end
         end
         DRAIN: begin
            if (dcnt == '0) state_nxt = DONE;
            else            dcnt_nxt  = dcnt - DW'(1);
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (bus.i_abort) begin
         state_nxt = IDLE;
         k_nxt     = k_reg;
         addr_nxt  = '0;
         dcnt_nxt  = '0;
      end
   end

   assign bus.o_busy       = (state != IDLE);
   assign bus.o_pe_clear   = (state == CLEAR);
   assign bus.o_rd_en      = rd_en;
   assign bus.o_rd_addr    = rd_en ? addr : '0;
   assign bus.o_feed_valid = vld_pipe;
   assign bus.o_capture    = (state == DONE);
   assign bus.o_done       = (state == DONE);
endmodule

// File: tb/tb_pe_array_sequencer.sv
// Scoreboard bench for pe_array_sequencer: expected clear/address/done events are
// queued at start time and retired as the DUT emits them; busy and skew are checked each cycle.
module tb_pe_array_sequencer;
   localparam int N     = 4;
   localparam int K_W   = 8;
   localparam int P_LAT = 3;
   localparam int D     = 1 + 2 * (N - 1) + P_LAT;
   localparam int NEVER = 32'h7fff_ffff;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pe_array_sequencer_if #(.N(N), .K_W(K_W)) bus ();

   pe_array_sequencer #(.N(N), .K_W(K_W), .P_LAT(P_LAT)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {int c; int a;} rd_t;
   rd_t rd_q[$];
   int  clr_q[$];
   int  done_q[$];

   // The tile currently expected from the DUT (start cycle, K, last live cycle).
   int t0, tk, t_stop;
   bit t_act = 1'b0;

   task automatic chk(string tag, longint got, longint exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, "_busy"},  bus.o_busy, 0);
      chk({tag, "_clr"},   bus.o_pe_clear, 0);
      chk({tag, "_rden"},  bus.o_rd_en, 0);
      chk({tag, "_addr"},  bus.o_rd_addr, 0);
      chk({tag, "_feed"},  bus.o_feed_valid, 0);
      chk({tag, "_cap"},   bus.o_capture, 0);
      chk({tag, "_done"},  bus.o_done, 0);
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      int           c;
      int           tdone;
      logic [N-1:0] fv;
      logic         bz;
      rd_t          e;
      if (!rst) begin
         c = cyc;
         if (bus.o_pe_clear || (clr_q.size() > 0 && clr_q[0] <= c)) begin
            if (clr_q.size() == 0) chk("clr_unexp", bus.o_pe_clear, 0);
            else chk("clr_at", bus.o_pe_clear ? c : -1, clr_q.pop_front());
         end
         if (bus.o_rd_en || (rd_q.size() > 0 && rd_q[0].c <= c)) begin
            if (rd_q.size() == 0) chk("rd_unexp", bus.o_rd_en, 0);
            else begin
               e = rd_q.pop_front();
               chk("rd_at", bus.o_rd_en ? c : -1, e.c);
               chk("rd_addr", bus.o_rd_addr, e.a);
            end
         end
         if (bus.o_done || bus.o_capture || (done_q.size() > 0 && done_q[0] <= c)) begin
            if (done_q.size() == 0) chk("done_unexp", bus.o_done, 0);
            else chk("done_at", bus.o_done ? c : -1, done_q.pop_front());
            chk("capture", bus.o_capture, bus.o_done);
         end
         tdone = (tk == 0) ? t0 + 2 : t0 + tk + 2 + D;
         bz = t_act && c <= t_stop && c >= t0 + 1 && c <= tdone;
         for (int r = 0; r < N; r++)
            fv[r] = t_act && c <= t_stop && c >= t0 + 3 + r && c <= t0 + tk + 2 + r;
         chk("busy", bus.o_busy, bz);
         chk("feed", bus.o_feed_valid, fv);
      end
   end

   task automatic start_tile(int k);
      rd_t e;
      bus.i_start = 1'b1;
      bus.i_k_len = K_W'(k);
      t0 = cyc; tk = k; t_stop = NEVER; t_act = 1'b1;
      clr_q.push_back(cyc + 1);
      for (int i = 0; i < k; i++) begin
         e.c = cyc + 2 + i; e.a = i;
         rd_q.push_back(e);
      end
      done_q.push_back(k == 0 ? cyc + 2 : cyc + k + 2 + D);
      @(negedge clk);
      bus.i_start = 1'b0;
   endtask

   // A start the DUT must ignore because it is busy.
   task automatic stray_start(int k);
      bus.i_start = 1'b1;
      bus.i_k_len = K_W'(k);
      @(negedge clk);
      bus.i_start = 1'b0;
   endtask

   task automatic cut(int a);
      t_stop = a;
      while (rd_q.size() > 0 && rd_q[rd_q.size()-1].c > a) void'(rd_q.pop_back());
      while (clr_q.size() > 0 && clr_q[clr_q.size()-1] > a) void'(clr_q.pop_back());
      while (done_q.size() > 0 && done_q[done_q.size()-1] > a) void'(done_q.pop_back());
   endtask

   task automatic abort_now();
      bus.i_abort = 1'b1;
      cut(cyc);
      @(negedge clk);
      bus.i_abort = 1'b0;
   endtask

   task automatic wait_to(int c);
      while (cyc < c) @(negedge clk);
   endtask

   initial begin
      int s;
      bus.i_start = 1'b0; bus.i_k_len = '0; bus.i_abort = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_all_zero("rst");
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // Nominal K=5: done at +17.
      start_tile(5);
      wait_to(t0 + 19);

      // K=0 then back-to-back K=255.
      start_tile(0);
      wait_to(t0 + 3);
      start_tile(255);
      wait_to(t0 + 268);

      // Starts during FEED and DRAIN are ignored; restart right after done.
      start_tile(5); s = t0;
      wait_to(s + 4);  stray_start(9);
      wait_to(s + 12); stray_start(9);
      wait_to(s + 18);
      bus.i_abort = 1'b0;
      start_tile(2);
      wait_to(t0 + 16);

      // Abort in FEED, then in DRAIN.
      start_tile(8); s = t0;
      wait_to(s + 6); abort_now();
      chk("abort_feed_busy", bus.o_busy, 0);
      chk("abort_feed_rden", bus.o_rd_en, 0);
      wait_to(s + 37);
      start_tile(8); s = t0;
      wait_to(s + 14); abort_now();
      chk("abort_drain_busy", bus.o_busy, 0);
      wait_to(s + 45);

      // Abort together with start in IDLE: stays idle.
      bus.i_start = 1'b1; bus.i_k_len = 8'd3; bus.i_abort = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0; bus.i_abort = 1'b0;
      chk("abort_start_busy", bus.o_busy, 0);
      repeat (5) @(negedge clk);

      // Asynchronous reset between edges mid-tile.
      start_tile(8); s = t0;
      wait_to(s + 9);
      #2;
      cut(cyc);
      rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      #1;
      rst = 1'b0;
      wait_to(s + 12);
      start_tile(1);
      wait_to(t0 + 20);

      chk("rd_left",   rd_q.size(), 0);
      chk("clr_left",  clr_q.size(), 0);
      chk("done_left", done_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got cycle %0d expected completion", cyc);
      $fatal(1);
   end
endmodule
